// File: rtl/cong_noi_tiep.sv
// Bit-serial N-bit adder: {co,s} = a + b + ci, one full-adder bit per clock, LSB first.
// Latency: accept edge E0, N RUN edges, done high for the single cycle after edge EN.
// Handshake: start sampled only in IDLE; ignored in RUN/DONE (no queuing), next accept at E(N+2).
module cong_noi_tiep #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         co,
    output logic         ovf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_ra;
    logic [N-1:0]    r_rb;
    logic [N-1:0]    r_acc;      // sum bits shift in at the MSB while running
    logic [N-1:0]    r_s;        // published result, only touched on the final edge
    logic            r_carry;
    logic            r_cin_msb;  // carry into bit N-1, kept for the overflow flag
    logic            r_co;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   r_cnt;

    logic            w_x;
    logic            w_y;
    logic            w_sum;
    logic            w_cout;
    logic            w_last;
    logic [N-1:0]    w_acc_nxt;

    // single full-adder cell working on the current LSBs
    assign w_x       = r_ra[0];
    assign w_y       = r_rb[0];
    assign w_sum     = w_x ^ w_y ^ r_carry;
    assign w_cout    = (w_x & w_y) | ((w_x ^ w_y) & r_carry);
    assign w_last    = (r_cnt == CW'(N - 1));
    assign w_acc_nxt = {w_sum, r_acc[N-1:1]};

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;
    // both terms are flops updated on the same final edge, so ovf is valid with done
    assign ovf  = r_cin_msb ^ r_co;

    // control FSM and serial datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ra      <= '0;
            r_rb      <= '0;
            r_acc     <= '0;
            r_s       <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_co      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_carry <= ci;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_cout;
                    r_ra    <= {1'b0, r_ra[N-1:1]};
                    r_rb    <= {1'b0, r_rb[N-1:1]};
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cin_msb <= r_carry;
                        r_s       <= w_acc_nxt;
                        r_co      <= w_cout;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cong_noi_tiep.sv
// Directed and randomised checks of the bit-serial adder against a + b + ci.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Every wait on done is bounded by a cycle budget.
module tb_cong_noi_tiep;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         co;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    cong_noi_tiep #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // one run from IDLE; optionally scrambles the operand inputs mid-run
    task automatic do_add(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tci, input logic scramble);
        logic [N:0] full;
        logic       exp_ovf;
        int         k;
        int         busy_cnt;
        logic       both;
        logic       seen;
        full    = {1'b0, ta} + {1'b0, tb} + {{N{1'b0}}, tci};
        exp_ovf = (ta[N-1] == tb[N-1]) && (full[N-1] != ta[N-1]);
        @(negedge clk);
        a = ta; b = tb; ci = tci; start = 1'b1;
        @(posedge clk);                    // E0
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; both = 1'b0; seen = 1'b0; k = 1;
        while (k <= 3 * N) begin
            if (busy) busy_cnt++;
            if (busy && done) both = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (scramble && k == 2) begin
                a = ~ta; b = ta ^ tb; ci = ~tci;
            end
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(k), 32'(N + 1));
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N));
            chk({tag, "_busy_done_excl"}, 32'(both), 32'd0);
            chk({tag, "_s"}, 32'(s), 32'(full[N-1:0]));
            chk({tag, "_co"}, 32'(co), 32'(full[N]));
            chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        end
        @(negedge clk);
        chk({tag, "_done_pulse_1"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int bad_gap;
        int wide;
        logic prev_done;
        logic [N-1:0] ra_v;
        logic [N-1:0] rb_v;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // leave non-zero outputs so the reset-abort clearing is visible
        do_add("pre", 8'hFF, 8'hFF, 1'b1, 1'b0);

        // reset mid-run: rst seen on the 4th RUN edge
        @(negedge clk);
        a = 8'h5A; b = 8'h33; ci = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_co", 32'(co), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // directed vectors
        do_add("basic", 8'd100, 8'd27, 1'b0, 1'b0);
        chk("basic_s_val", 32'(s), 32'd127);
        do_add("wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
        chk("wrap_co_val", 32'(co), 32'd1);
        do_add("wrap_ci", 8'hFF, 8'hFF, 1'b1, 1'b0);
        chk("wrap_ci_s_val", 32'(s), 32'hFF);
        do_add("sovf_pos", 8'h7F, 8'h01, 1'b0, 1'b0);
        chk("sovf_pos_ovf_val", 32'(ovf), 32'd1);
        do_add("sovf_neg", 8'h80, 8'h80, 1'b0, 1'b0);
        chk("sovf_neg_co_val", 32'(co), 32'd1);
        do_add("inverse", 8'hC3, 8'h4E, 1'b0, 1'b0);
        chk("inverse_s_val", 32'(s), 32'h11);
        do_add("scramble", 8'h3C, 8'hA5, 1'b1, 1'b1);
        chk("scramble_s_val", 32'(s), 32'hE2);

        // start held high for 30 cycles: accepts at E0, E10, E20
        @(negedge clk);
        a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
        done_cnt = 0; last_done = -1; bad_gap = 0; wide = 0; prev_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done) wide++;
                if (last_done >= 0 && (i - last_done) != N + 2) bad_gap++;
                last_done = i;
                done_cnt++;
                if (s !== 8'h46) bad_gap++;
            end
            prev_done = done;
        end
        start = 1'b0;
        chk("held_done_count", 32'(done_cnt), 32'd3);
        chk("held_period", 32'(bad_gap), 32'd0);
        chk("held_pulse_width", 32'(wide), 32'd0);
        repeat (N + 4) @(negedge clk);

        // random sweep
        for (int i = 0; i < 1000; i++) begin
            ra_v = N'($urandom);
            rb_v = N'($urandom);
            do_add("rand", ra_v, rb_v, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
